// File: rtl/pc_flow_ctrl_pkg.sv
// Shared encodings for the pipeline flow controller: PC-select codes and FSM states.
package pc_flow_ctrl_pkg;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_JALR = 2'b01;
    localparam logic [1:0] PC_SEL_BR   = 2'b10;
    localparam logic [1:0] PC_SEL_TRAP = 2'b11;

    typedef enum logic [1:0] {
        FC_RUN   = 2'b00,
        FC_DRAIN = 2'b01,
        FC_HALT  = 2'b10
    } fc_state_e;

endpackage

// File: rtl/pc_flow_ctrl_load_use_detect.sv
// Load-use hazard detector: an EX load writes a register that ID is about to read.
module load_use_detect (
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);

    // x0 is hard-wired to zero, so a load into it never creates a dependency.
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pc_flow_ctrl.sv
// Pipeline flow controller: PC/IF/ID sequencing, memory-port arbitration,
// load-use stalls, trap drain-and-halt, and stall/flush performance counters.
module pc_flow_ctrl
    import pc_flow_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       pc_selection,
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             mem_busy,
    input  logic             resume,
    output logic [1:0]       pc_src,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    fc_state_e  state_q, state_d;
    logic [3:0] drain_q;
    logic       load_use;
    logic       redirect;
    logic       stall_evt;

    load_use_detect u_load_use_detect (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .load_use   (load_use)
    );

    assign state = state_q;

    always_comb begin
        state_d    = state_q;
        pc_src     = PC_SEL_SEQ;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;
        redirect   = 1'b0;
        stall_evt  = 1'b0;
        case (state_q)
            FC_RUN: begin
                // Redirect wins: everything younger than EX is wrong-path.
                if (ex_valid && (pc_selection != PC_SEL_SEQ)) begin
                    redirect   = 1'b1;
                    pc_src     = pc_selection;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (pc_selection == PC_SEL_TRAP) begin
                        state_d = FC_DRAIN;
                    end
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    stall_evt  = 1'b1;
                end else if (mem_busy) begin
                    // Fetch loses the port; ID still advances and IF/ID gets a bubble.
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    stall_evt  = 1'b1;
                end
            end
            FC_DRAIN: begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (drain_q == 4'd0) begin
                    state_d = FC_HALT;
                end
            end
            FC_HALT: begin
                halted     = 1'b1;
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (resume) begin
                    state_d = FC_RUN;
                end
            end
            default: begin
                state_d = FC_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FC_RUN;
            drain_q   <= 4'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == FC_RUN) && (state_d == FC_DRAIN)) begin
                drain_q <= DRAIN_LOAD;
            end else if ((state_q == FC_DRAIN) && (drain_q != 4'd0)) begin
                drain_q <= drain_q - 4'd1;
            end
            if (stall_evt) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (redirect) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Self-checking bench for pc_flow_ctrl: table-driven RUN vectors, trap/halt and reset sequences.
module tb_pc_flow_ctrl;
    localparam int CNT_W = 32;
    localparam int W     = 2 * CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       pc_selection;
    logic             ex_valid, ex_memread, mem_busy, resume;
    logic [4:0]       ex_rd, id_rs1, id_rs2;
    logic [1:0]       pc_src;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0]       state;

    pc_flow_ctrl #(.DRAIN_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pc_selection(pc_selection), .ex_valid(ex_valid),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .mem_busy(mem_busy), .resume(resume), .pc_src(pc_src), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] sel;
        logic       valid, memread;
        logic [4:0] rd, rs1, rs2;
        logic       busy, res;
        logic [1:0] e_src;
        logic       e_pcw, e_ifw, e_iff, e_idf, e_halt;
        logic [1:0] e_state;
        logic       s_inc, f_inc;
    } vec_t;

    // scoreboard
    logic [W-1:0]     exp_q[$];
    logic [CNT_W-1:0] m_stall, m_flush;
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // driver tasks
    task automatic drive(input vec_t v);
        pc_selection = v.sel;
        ex_valid     = v.valid;
        ex_memread   = v.memread;
        ex_rd        = v.rd;
        id_rs1       = v.rs1;
        id_rs2       = v.rs2;
        mem_busy     = v.busy;
        resume       = v.res;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [W-1:0] got;
        drive(v);
        m_stall = m_stall + CNT_W'(v.s_inc);
        m_flush = m_flush + CNT_W'(v.f_inc);
        exp_q.push_back({m_stall, m_flush});
        #1;
        chk({tag, ".state"},      W'(state),      W'(v.e_state));
        chk({tag, ".pc_src"},     W'(pc_src),     W'(v.e_src));
        chk({tag, ".pc_write"},   W'(pc_write),   W'(v.e_pcw));
        chk({tag, ".ifid_write"}, W'(ifid_write), W'(v.e_ifw));
        chk({tag, ".ifid_flush"}, W'(ifid_flush), W'(v.e_iff));
        chk({tag, ".idex_flush"}, W'(idex_flush), W'(v.e_idf));
        chk({tag, ".halted"},     W'(halted),     W'(v.e_halt));
        @(posedge clk);
        #1;
        got = {stall_cnt, flush_cnt};
        chk({tag, ".counters"}, got, exp_q.pop_front());
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_stall = '0;
        m_flush = '0;
        exp_q.delete();
        chk({tag, ".state"},   W'(state),  W'(2'b00));
        chk({tag, ".halted"},  W'(halted), W'(1'b0));
        chk({tag, ".counters"}, {stall_cnt, flush_cnt}, '0);
    endtask

    vec_t tbl[12];
    vec_t idle, trap, drain_noise, drain_idle, halt_idle, halt_res;

    initial begin
        //            sel    vld   mrd   rd     rs1    rs2    busy  res   src    pcw   ifw   iff   idf   hlt   st     sinc  finc
        idle        = '{2'b00,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0};
        trap        = '{2'b11,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,2'b11,1'b1,1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,1'b1};
        drain_noise = '{2'b10,1'b1,1'b1,5'd5, 5'd5, 5'd0, 1'b1,1'b1,2'b00,1'b0,1'b1,1'b1,1'b1,1'b0,2'b01,1'b0,1'b0};
        drain_idle  = '{2'b00,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,1'b1,1'b0,2'b01,1'b0,1'b0};
        halt_idle   = '{2'b00,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,1'b1,1'b1,2'b10,1'b0,1'b0};
        halt_res    = '{2'b00,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1,2'b00,1'b0,1'b1,1'b1,1'b1,1'b1,2'b10,1'b0,1'b0};

        tbl[0]  = idle;
        tbl[1]  = '{2'b10,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,2'b10,1'b1,1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,1'b1};
        tbl[2]  = '{2'b01,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,2'b01,1'b1,1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,1'b1};
        tbl[3]  = '{2'b00,1'b1,1'b1,5'd5, 5'd0, 5'd5, 1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b1,1'b0};
        tbl[4]  = '{2'b00,1'b1,1'b1,5'd0, 5'd0, 5'd0, 1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0};
        tbl[5]  = '{2'b10,1'b1,1'b1,5'd5, 5'd5, 5'd0, 1'b1,1'b0,2'b10,1'b1,1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,1'b1};
        tbl[6]  = '{2'b00,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b0,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b1,1'b0};
        tbl[7]  = '{2'b10,1'b0,1'b1,5'd7, 5'd7, 5'd1, 1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b1,1'b0};
        tbl[8]  = '{2'b00,1'b1,1'b1,5'd3, 5'd4, 5'd5, 1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0};
        tbl[9]  = '{2'b00,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b1,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0};
        tbl[10] = '{2'b00,1'b1,1'b1,5'd31,5'd31,5'd2, 1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b1,1'b0};
        tbl[11] = '{2'b11,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0};

        drive(idle);
        m_stall = '0;
        m_flush = '0;
        do_reset("reset");

        for (int i = 0; i < 10; i++) run_vec(idle, $sformatf("idle%0d", i));

        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // randomised replay of the table for extra counter coverage
        for (int i = 0; i < 20; i++) begin
            int k;
            k = $urandom_range(0, 11);
            run_vec(tbl[k], $sformatf("rnd%0d_vec%0d", i, k));
        end

        // trap at t: DRAIN t+1..t+2, HALT from t+3, resume at t+6, RUN at t+7
        run_vec(trap,        "trap_t");
        run_vec(drain_noise, "drain_t1");
        run_vec(drain_idle,  "drain_t2");
        run_vec(halt_idle,   "halt_t3");
        run_vec(halt_idle,   "halt_t4");
        run_vec(halt_idle,   "halt_t5");
        run_vec(halt_res,    "halt_t6");
        run_vec(idle,        "run_t7");
        run_vec(tbl[1],      "run_t8_redirect");

        // reset overrides HALT; resume in RUN is ignored
        run_vec(trap,       "trap2");
        run_vec(drain_idle, "trap2_d1");
        run_vec(drain_idle, "trap2_d2");
        run_vec(halt_idle,  "trap2_h");
        drive(idle);
        do_reset("rst_in_halt");
        run_vec(tbl[9], "resume_in_run");
        run_vec(idle,   "after_resume");

        // reset during DRAIN
        run_vec(trap, "trap3");
        drive(idle);
        do_reset("rst_in_drain");
        run_vec(idle, "after_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
